// File: rtl/tx_serializer_pkg.sv
// Shared types and constants for the USB transmit byte serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_e;

  // Six consecutive ones on the wire force a stuffed zero.
  localparam int BIT_STUFF_LIMIT = 6;

  // Wide enough to count up to BIT_STUFF_LIMIT.
  localparam int ONES_CNT_W = 3;

endpackage

// File: rtl/tx_byte_serializer_if.sv
// FIFO read side plus bit-stream side of the transmit serializer.
// Latency: n/a (wiring only).
// Backpressure: bitReq_i from the line encoder, fifoEmpty_i from the FIFO.
interface tx_byte_serializer_if #(
  parameter int DATA_WID = 8
);

  logic                fifoEmpty_i;
  logic [DATA_WID-1:0] fifoData_i;
  logic                fifoPop_o;
  logic                txEnable_i;
  logic                bitReq_i;
  logic                bit_o;
  logic                bitValid_o;
  logic                stuffedBit_o;
  logic                done_o;

  // Serializer side: consumes FIFO words, produces the bit stream.
  modport master (
    input  fifoEmpty_i, fifoData_i, txEnable_i, bitReq_i,
    output fifoPop_o, bit_o, bitValid_o, stuffedBit_o, done_o
  );

  // Environment side: FIFO, producer and line encoder.
  modport slave (
    output fifoEmpty_i, fifoData_i, txEnable_i, bitReq_i,
    input  fifoPop_o, bit_o, bitValid_o, stuffedBit_o, done_o
  );

endinterface

// File: rtl/usb_bit_stuffer.sv
// Tracks the run of consecutive ones and flags when a stuff zero is owed.
// Latency: stuff_pending registers one cycle after the sixth one is taken; stuff_pending_nxt is same-cycle.
// Backpressure: advances only on handshakes; state held otherwise.
module usb_bit_stuffer
  import tx_serializer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  logic data_hs,
  input  logic stuff_hs,
  input  logic data_bit,
  output logic stuff_pending,
  output logic stuff_pending_nxt
);

  logic [ONES_CNT_W-1:0] ones_cnt;
  logic [ONES_CNT_W-1:0] ones_cnt_nxt;

  // Next run length / pending flag from the current handshake.
  always_comb begin
    ones_cnt_nxt      = ones_cnt;
    stuff_pending_nxt = stuff_pending;
    if (start) begin
      ones_cnt_nxt      = '0;
      stuff_pending_nxt = 1'b0;
    end else if (stuff_hs) begin
      ones_cnt_nxt      = '0;
      stuff_pending_nxt = 1'b0;
    end else if (data_hs) begin
      if (data_bit) begin
        ones_cnt_nxt = ones_cnt + ONES_CNT_W'(1);
        if (ones_cnt_nxt == ONES_CNT_W'(BIT_STUFF_LIMIT)) begin
          stuff_pending_nxt = 1'b1;
        end
      end else begin
        ones_cnt_nxt = '0;
      end
    end
  end

  // Run length and pending flag survive byte boundaries and FIFO underruns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ones_cnt      <= '0;
      stuff_pending <= 1'b0;
    end else begin
      ones_cnt      <= ones_cnt_nxt;
      stuff_pending <= stuff_pending_nxt;
    end
  end

endmodule

// File: rtl/tx_byte_serializer.sv
// Pops FIFO bytes and emits them LSB-first with USB bit stuffing, then pulses done_o.
// Latency: first bit one cycle after the pop; back-to-back bytes with no bubble.
// Backpressure: bit held stable until bitReq_i; FIFO underrun parks in STALL with bitValid_o low.
module tx_byte_serializer
  import tx_serializer_pkg::*;
#(
  parameter int DATA_WID = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tx_byte_serializer_if.master   bus
);

  localparam int               CNT_W    = $clog2(DATA_WID);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WID - 1);

  state_e              state;
  logic [DATA_WID-1:0] shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic                tail_stuff;   // only a trailing stuff bit is left in this packet

  logic hs;
  logic data_hs;
  logic stuff_hs;
  logic pkt_start;
  logic last_hs;
  logic stuff_pending;
  logic stuff_pending_nxt;

  assign hs        = bus.bitValid_o && bus.bitReq_i;
  assign data_hs   = hs && !stuff_pending;
  assign stuff_hs  = hs && stuff_pending;
  assign pkt_start = (state == IDLE) && bus.txEnable_i && !bus.fifoEmpty_i;
  assign last_hs   = (state == SEND) && data_hs && (bit_cnt == LAST_BIT);

  // Pop is combinational so the next byte loads in the same cycle; never while resetting.
  assign bus.fifoPop_o = !rst_i && !bus.fifoEmpty_i && (pkt_start || last_hs || (state == STALL));

  usb_bit_stuffer u_stuffer (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start             (pkt_start),
    .data_hs           (data_hs),
    .stuff_hs          (stuff_hs),
    .data_bit          (shift_reg[0]),
    .stuff_pending     (stuff_pending),
    .stuff_pending_nxt (stuff_pending_nxt)
  );

  // Packet FSM; the offered bit and its flags are registered from the next-cycle view.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      shift_reg        <= '0;
      bit_cnt          <= '0;
      tail_stuff       <= 1'b0;
      bus.bitValid_o   <= 1'b0;
      bus.bit_o        <= 1'b0;
      bus.stuffedBit_o <= 1'b0;
      bus.done_o       <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_start) begin
            shift_reg        <= bus.fifoData_i;
            bit_cnt          <= '0;
            state            <= SEND;
            bus.bitValid_o   <= 1'b1;
            bus.bit_o        <= bus.fifoData_i[0];
            bus.stuffedBit_o <= 1'b0;
          end
        end
        SEND: begin
          if (stuff_hs) begin
            if (tail_stuff) begin
              state            <= IDLE;
              tail_stuff       <= 1'b0;
              bus.bitValid_o   <= 1'b0;
              bus.bit_o        <= 1'b0;
              bus.stuffedBit_o <= 1'b0;
              bus.done_o       <= 1'b1;
            end else begin
              // Shift already happened on the preceding data handshake.
              bus.bit_o        <= shift_reg[0];
              bus.stuffedBit_o <= 1'b0;
            end
          end else if (data_hs) begin
            if (bit_cnt != LAST_BIT) begin
              shift_reg        <= shift_reg >> 1;
              bit_cnt          <= bit_cnt + CNT_W'(1);
              bus.bit_o        <= !stuff_pending_nxt && shift_reg[1];
              bus.stuffedBit_o <= stuff_pending_nxt;
            end else if (!bus.fifoEmpty_i) begin
              shift_reg        <= bus.fifoData_i;
              bit_cnt          <= '0;
              bus.bit_o        <= !stuff_pending_nxt && bus.fifoData_i[0];
              bus.stuffedBit_o <= stuff_pending_nxt;
            end else if (bus.txEnable_i) begin
              state            <= STALL;
              bit_cnt          <= '0;
              bus.bitValid_o   <= 1'b0;
              bus.bit_o        <= 1'b0;
              bus.stuffedBit_o <= 1'b0;
            end else if (stuff_pending_nxt) begin
              tail_stuff       <= 1'b1;
              bit_cnt          <= '0;
              bus.bit_o        <= 1'b0;
              bus.stuffedBit_o <= 1'b1;
            end else begin
              state            <= IDLE;
              bit_cnt          <= '0;
              bus.bitValid_o   <= 1'b0;
              bus.bit_o        <= 1'b0;
              bus.stuffedBit_o <= 1'b0;
              bus.done_o       <= 1'b1;
            end
          end
        end
        STALL: begin
          if (!bus.fifoEmpty_i) begin
            shift_reg        <= bus.fifoData_i;
            bit_cnt          <= '0;
            state            <= SEND;
            bus.bitValid_o   <= 1'b1;
            bus.bit_o        <= !stuff_pending && bus.fifoData_i[0];
            bus.stuffedBit_o <= stuff_pending;
          end else if (!bus.txEnable_i) begin
            if (stuff_pending) begin
              state            <= SEND;
              tail_stuff       <= 1'b1;
              bus.bitValid_o   <= 1'b1;
              bus.bit_o        <= 1'b0;
              bus.stuffedBit_o <= 1'b1;
            end else begin
              state      <= IDLE;
              bus.done_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_byte_serializer.sv
// Bench for the USB transmit byte serializer: FIFO model, random packets, bit-stream scoreboard.
// Latency: n/a.
// Backpressure: bitReq_i driven always-on, toggling or random per packet.
module tb_tx_byte_serializer;

  typedef logic [7:0] byte_q_t[$];

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [7:0] fifo_q[$];

  tx_byte_serializer_if #(.DATA_WID(8)) bus ();

  tx_byte_serializer #(.DATA_WID(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one packet through the FIFO model and score the resulting stream.
  task automatic run_pkt(input byte_q_t bytes, input int req_mode, input int gap);
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    byte_q_t    pending;
    logic [7:0] b;
    int ones = 0;
    int t = 0;
    int pops = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_pop = -1;
    int first_valid = -1;
    int first_hs = -1;
    int last_hs = -1;
    int write_cyc = -1;
    int wrote_at = -1;
    int data_cnt = 0;
    int invalid_cnt = 0;
    logic pop_now;
    logic prev_valid = 1'b0;
    logic prev_req = 1'b0;
    logic prev_bit = 1'b0;
    logic prev_stuff = 1'b0;

    // Reference stream: LSB-first bits, a flagged zero after every run of six ones.
    foreach (bytes[k]) begin
      b = bytes[k];
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back({1'b0, b[i]});
        if (b[i]) ones++;
        else ones = 0;
        if (ones == 6) begin
          exp_q.push_back(2'b10);
          ones = 0;
        end
      end
    end

    if (gap == 0) begin
      foreach (bytes[k]) fifo_q.push_back(bytes[k]);
      wrote_at = 0;
    end else begin
      fifo_q.push_back(bytes[0]);
      for (int k = 1; k < bytes.size(); k++) pending.push_back(bytes[k]);
    end

    while ((done_cyc < 0 || t < done_cyc + 3) && t < 3000) begin
      if (pending.size() != 0 && write_cyc >= 0 && t >= write_cyc) begin
        while (pending.size() != 0) fifo_q.push_back(pending.pop_front());
        wrote_at = t;
      end
      bus.txEnable_i  = (pending.size() != 0) || (t == wrote_at);
      bus.fifoEmpty_i = (fifo_q.size() == 0);
      bus.fifoData_i  = bus.fifoEmpty_i ? 8'($urandom) : fifo_q[0];
      case (req_mode)
        0:       bus.bitReq_i = 1'b1;
        1:       bus.bitReq_i = (t % 2 == 0);
        default: bus.bitReq_i = 1'($urandom_range(0, 1));
      endcase

      @(negedge clk);
      if (prev_valid && !prev_req)
        chk("hold", 32'({bus.bitValid_o, bus.bit_o, bus.stuffedBit_o}),
            32'({1'b1, prev_bit, prev_stuff}));
      if (bus.done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = t;
      end
      if (bus.bitValid_o && first_valid < 0) first_valid = t;
      if (!bus.bitValid_o && first_valid >= 0 && done_cyc < 0) invalid_cnt++;
      if (bus.bitValid_o && bus.bitReq_i) begin
        obs_q.push_back({bus.stuffedBit_o, bus.bit_o});
        if (first_hs < 0) first_hs = t;
        last_hs = t;
        if (!bus.stuffedBit_o) begin
          data_cnt++;
          if (data_cnt == 8 && gap > 0) write_cyc = t + gap;
        end
      end
      pop_now = bus.fifoPop_o;
      if (pop_now) begin
        chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
        pops++;
        if (first_pop < 0) first_pop = t;
      end
      prev_valid = bus.bitValid_o;
      prev_req   = bus.bitReq_i;
      prev_bit   = bus.bit_o;
      prev_stuff = bus.stuffedBit_o;

      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() != 0) b = fifo_q.pop_front();
      t++;
    end

    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("done_cnt", 32'(done_cnt), 32'd1);
    chk("done_at", 32'(done_cyc), 32'(last_hs + 1));
    chk("pops", 32'(pops), 32'(bytes.size()));
    chk("start_lat", 32'(first_valid), 32'(first_pop + 1));
    chk("n_bits", 32'(obs_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      chk($sformatf("bit%0d", i), 32'((i < obs_q.size()) ? obs_q[i] : 2'b11), 32'(exp_q[i]));
    if (req_mode == 0 && gap == 0)
      chk("no_bubble", 32'(last_hs - first_hs + 1), 32'(exp_q.size()));
    if (req_mode == 0 && gap > 0)
      chk("stall_gap", 32'(invalid_cnt), 32'(gap));
    fifo_q.delete();
  endtask

  initial begin
    byte_q_t pkt;
    int hs_cnt;
    int guard;
    int n;
    int gap;
    logic [7:0] b;
    logic pop_now;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.fifoEmpty_i = 1'b1;
    bus.fifoData_i  = 8'h00;
    bus.txEnable_i  = 1'b0;
    bus.bitReq_i    = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.bitValid_o), 32'd0);
    chk("rst_pop", 32'(bus.fifoPop_o), 32'd0);
    chk("rst_bit", 32'(bus.bit_o), 32'd0);
    chk("rst_stuffed", 32'(bus.stuffedBit_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed packets.
    pkt = '{8'hA5};        run_pkt(pkt, 0, 0);
    pkt = '{8'hFF, 8'hFF}; run_pkt(pkt, 0, 0);
    pkt = '{8'hFC};        run_pkt(pkt, 0, 0);
    pkt = '{8'h5A};        run_pkt(pkt, 1, 0);
    pkt = '{8'hF0, 8'h03}; run_pkt(pkt, 0, 5);

    // Reset after three bits of 0xFF.
    fifo_q.push_back(8'hFF);
    hs_cnt = 0;
    guard = 0;
    while (hs_cnt < 3 && guard < 20) begin
      bus.txEnable_i  = 1'b1;
      bus.fifoEmpty_i = (fifo_q.size() == 0);
      bus.fifoData_i  = bus.fifoEmpty_i ? 8'h00 : fifo_q[0];
      bus.bitReq_i    = 1'b1;
      @(negedge clk);
      if (bus.bitValid_o && bus.bitReq_i) hs_cnt++;
      pop_now = bus.fifoPop_o;
      @(posedge clk);
      #1;
      if (pop_now && fifo_q.size() != 0) b = fifo_q.pop_front();
      guard++;
    end
    chk("rst_mid_reached", 32'(hs_cnt), 32'd3);
    fifo_q.push_back(8'hFF);
    rst = 1'b1;
    bus.txEnable_i  = 1'b0;
    bus.fifoEmpty_i = 1'b0;
    bus.fifoData_i  = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.bitValid_o), 32'd0);
    chk("rst_mid_pop", 32'(bus.fifoPop_o), 32'd0);
    chk("rst_mid_done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    #1;
    fifo_q.delete();
    pkt = '{8'hFF}; run_pkt(pkt, 0, 0);

    // Random packets, biased toward long runs of ones.
    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       pkt.push_back(8'($urandom));
          1:       pkt.push_back(8'hFF);
          2:       pkt.push_back(8'hFE);
          default: pkt.push_back(8'h3F);
        endcase
      end
      gap = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      run_pkt(pkt, $urandom_range(0, 2), gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_byte_serializer.md
# tx_byte_serializer

Transmit-path stage that sits directly on the read side of the USB controller's async FIFO in the USB clock domain. It pops bytes from the FIFO and serializes them LSB-first into a bit stream, inserting USB bit-stuffing zeros after six consecutive ones. The bit stream is offered to the downstream line encoder under a valid/request handshake. The block signals the end of a packet once the producer has finished and all bits, including any trailing stuff bit, have been taken.

## Interface
- DATA_WID, 8, FIFO word width; bits per byte serialized.
- clk_i  in  1  USB-domain clock (FIFO read clock).
- rst_i  in  1  synchronous, active-high reset.
- fifoEmpty_i  in  1  FIFO empty flag.
- fifoData_i  in  DATA_WID  FIFO head word, first-word-fall-through, valid when !fifoEmpty_i.
- fifoPop_o  out  1  pop request; only asserted when !fifoEmpty_i.
- txEnable_i  in  1  packet in progress; producer drops it after writing the last byte.
- bitReq_i  in  1  downstream takes the offered bit this cycle.
- bit_o  out  1  offered bit.
- bitValid_o  out  1  bit_o is valid.
- stuffedBit_o  out  1  offered bit is a stuff bit (bit_o=0).
- done_o  out  1  one-cycle end-of-packet pulse.

## Operation
- States: IDLE, SEND, STALL.
- A handshake is bitValid_o && bitReq_i. bitReq_i is ignored while bitValid_o=0.
- IDLE:
  - bitValid_o=0.
  - If txEnable_i && !fifoEmpty_i: fifoPop_o=1 (combinational); capture fifoData_i into shiftReg; bitCnt=0; onesCnt=0; go to SEND.
- SEND:
  - bitValid_o=1.
  - If stuffPending: bit_o=0 and stuffedBit_o=1. Else bit_o=shiftReg[0].
  - On a stuff handshake: clear stuffPending; onesCnt=0.
  - On a data handshake:
    - Shift right; bitCnt+1.
    - onesCnt becomes onesCnt+1 if the bit was 1, else 0.
    - If onesCnt reaches 6, set stuffPending.
  - On a data handshake of bit DATA_WID-1:
    - If !fifoEmpty_i: pop and load the next byte in the same cycle, bitCnt=0, stay in SEND. A set stuffPending is emitted before the new byte's bit 0.
    - Else if txEnable_i: go to STALL.
    - Else: go to IDLE with done_o=1, unless stuffPending is set, in which case stay in SEND until the stuff bit is taken, then go to IDLE with done_o=1.
- STALL (FIFO underrun mid-packet):
  - bitValid_o=0.
  - onesCnt and stuffPending are held.
  - If !fifoEmpty_i: pop, load, go to SEND.
  - Else if !txEnable_i: go to SEND if stuffPending, else go to IDLE with done_o=1.
- onesCnt is 3 bits and never exceeds 6. onesCnt carries across byte boundaries and STALL, and is cleared only at packet start, on a stuff handshake, on a 0 data bit, or by reset.
- bitCnt is $clog2(DATA_WID) bits.

## Timing
- Reset values: state=IDLE, fifoPop_o=0, bitValid_o=0, bit_o=0, stuffedBit_o=0, done_o=0, stuffPending=0, counters=0.
- A reset mid-packet discards the partial byte and does not pop.
- Start latency: IDLE pop in cycle N puts bit 0 on bit_o with bitValid_o=1 in cycle N+1.
- Back-to-back bytes: with bitReq_i held high there is no bubble. The last bit of byte k in cycle M is followed by byte k+1 bit 0, or a stuff bit, in cycle M+1.
- bit_o and stuffedBit_o are registered and stable while bitValid_o && !bitReq_i.
- At most one fifoPop_o per cycle; none while in SEND with bitCnt<DATA_WID-1.
- done_o is registered and asserts in the cycle after the final handshake. The block is in IDLE in that cycle and can accept a new packet in it.
- Simultaneous final handshake and fifoEmpty_i falling: the byte is loaded and the packet continues.

## Structure
- Package tx_serializer_pkg holds:
  - the state enum (IDLE, SEND, STALL);
  - BIT_STUFF_LIMIT=6;
  - the onesCnt width constant.
- One sub-module, usb_bit_stuffer. It holds onesCnt and stuffPending, with inputs for handshake, data bit, and packet start.
- The FSM, shift register and bitCnt live in the top level.

## Test plan
- Single byte 0xA5, txEnable_i dropped after write, bitReq_i=1:
  - bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles;
  - one pop; stuffedBit_o never set;
  - done_o one cycle after the 8th bit.
- Bytes 0xFF,0xFF:
  - 18 bits total, with stuff 0s at positions 6 and 13 (0-based) flagged by stuffedBit_o;
  - two pops; done_o after bit 17.
- Single byte 0xFC:
  - bits 0,0,1,1,1,1,1,1, then a trailing stuff 0;
  - done_o only after the stuff handshake.
- Backpressure: 0x5A with bitReq_i toggling every cycle:
  - bit_o/bitValid_o stable on non-request cycles;
  - sequence 0,1,0,1,1,0,1,0; exactly one pop.
- Underrun:
  - Send 0xF0, hold FIFO empty 5 cycles with txEnable_i=1, then write 0x03.
  - bitValid_o=0 in the gap, no pops.
  - A stuff bit follows 0x03 bit 1 (6 ones spanning the gap).
- Reset mid-packet:
  - rst_i after 3 bits of 0xFF: next cycle bitValid_o=0, fifoPop_o=0, done_o=0.
  - A new packet 0xFF then stuffs after its own 6th bit; onesCnt is not carried over.
